p4_serial_adder: RTL
====================

# p4_serial_adder

- Synchronous, handshaked sum engine; the responder side of the P4 operand/sum interface.
- Accepts one operand request (A, B, carry-in) per transaction and computes the sum serially in CHUNK-bit slices.
- Returns the DWIDTH-bit sum and carry-out on a registered output with valid/ready flow control.
- Sits where the bench or a system master drives operands and samples results, so its result stream is directly comparable to the combinational P4 sum sampled on `clk`.

## Interface
Parameters:
- DWIDTH, 32: operand and sum width. Must be an integer multiple of CHUNK.
- CHUNK, 8: bits added per CALC cycle. N = DWIDTH/CHUNK.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: operand request valid.
- in_ready  out  1: block can accept a request (high only in IDLE).
- a_i  in  DWIDTH: operand A.
- b_i  in  DWIDTH: operand B.
- cin_i  in  1: carry-in.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts the result.
- sum_o  out  DWIDTH: registered sum.
- cout_o  out  1: registered carry-out.
- op_count_o  out  CNT_W: number of completed output handshakes, modulo 2^CNT_W.

## Operation
States:
- IDLE: `in_ready`=1.
  - On `in_valid && in_ready` at a rising edge: capture `a_i`, `b_i` and `cin_i` into internal registers; chunk index ← 0; carry ← `cin_i`; go to CALC.
- CALC: each edge computes {c, s} = A[idx] + B[idx] + carry over CHUNK bits.
  - s is written into sum slice idx; carry ← c; idx ← idx+1.
  - After the edge that processes idx = N-1: `cout_o` ← final carry; go to DONE.
- DONE: `out_valid`=1.
  - `sum_o` and `cout_o` are held stable.
  - On `out_valid && out_ready` at an edge: `op_count_o` increments (wraps at 2^CNT_W); go to IDLE.

Arithmetic and output rules:
- Result: `sum_o` = (A + B + cin) mod 2^DWIDTH; `cout_o` = bit DWIDTH of the full sum.
- Inputs are sampled only at the accept edge. Changes on `a_i`/`b_i`/`cin_i` afterwards have no effect.
- One transaction in flight. `in_ready`=0 in CALC and DONE, so `in_valid` is ignored there.
- `in_ready` and `out_valid` are decoded from registered state only (no combinational path from `in_valid` or `out_ready`).
- `sum_o` may show partial slices during CALC. It is defined only while `out_valid`=1.

Reset (`rst_n` low, asynchronous, any state):
- State → IDLE; `sum_o`=0, `cout_o`=0, `out_valid`=0, `op_count_o`=0, `in_ready`=1.
- Any in-flight operation is discarded with no output.
- First accept is possible at the first rising edge after `rst_n` deasserts.

Boundary conditions:
- `out_ready` held low: stay in DONE indefinitely, outputs frozen, no accept.
- `out_ready` already high when DONE is entered: handshake completes at the first edge in DONE.
- CHUNK = DWIDTH (N=1): CALC lasts exactly one cycle.

## Timing
- Accept at edge k. CALC edges are k+1 … k+N. `out_valid` rises after edge k+N.
- Latency from accept to `out_valid` is N cycles (4 with defaults).
- Output handshake at edge k+N+1 at the earliest. `in_ready` is high again after that edge.
- Next accept at edge k+N+2. Maximum throughput is one operation per N+2 cycles.
- `op_count_o` updates on the same edge as the output handshake.

## Test plan
- Reset check: hold `rst_n` low, then release → `in_ready`=1, `out_valid`=0, `sum_o`=0, `cout_o`=0, `op_count_o`=0.
- Full carry ripple: A=0xFFFFFFFF, B=0x00000001, cin=0, `out_ready`=1 → `out_valid` exactly 4 cycles after accept; `sum_o`=0x00000000, `cout_o`=1, `op_count_o`=1.
- Carry-in: A=0x12345678, B=0x11111111, cin=1 → `sum_o`=0x2345678A, `cout_o`=0. Changing `a_i`/`b_i` during CALC leaves the result unchanged.
- Backpressure: `out_ready`=0 for 6 cycles after `out_valid` rises, `in_valid` held high with new operands → `sum_o`/`cout_o` stable, `in_ready`=0, no accept. Raise `out_ready` → one handshake, then IDLE.
- Reset mid-operation: assert `rst_n` low during the second CALC cycle → `out_valid` never rises, `op_count_o`=0. The next request, A=0x00000003, B=0x00000004, cin=0, gives 0x00000007.
- Counter wrap: CNT_W=4, 16 back-to-back random transactions checked against a reference model → `op_count_o` reads 15 after the 15th handshake and 0 after the 16th.

Source files
------------

// File: rtl/p4_serial_adder_if.sv
// p4_serial_adder_if: operand request / sum response bundle between a P4 master and the serial adder
interface p4_serial_adder_if #(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] a_i;
  logic [DWIDTH-1:0] b_i;
  logic              cin_i;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] sum_o;
  logic              cout_o;
  logic [CNT_W-1:0]  op_count_o;
  modport master (
    output in_valid, a_i, b_i, cin_i, out_ready,
    input  in_ready, out_valid, sum_o, cout_o, op_count_o
  );
  modport slave (
    input  in_valid, a_i, b_i, cin_i, out_ready,
    output in_ready, out_valid, sum_o, cout_o, op_count_o
  );
endinterface

// File: rtl/p4_serial_adder.sv
// p4_serial_adder: handshaked adder computing A+B+cin in CHUNK-bit slices, one slice per cycle
module p4_serial_adder #(
  parameter int DWIDTH = 32,
  parameter int CHUNK  = 8,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst_n,
  p4_serial_adder_if.slave bus
);
  localparam int N  = DWIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            state_q;
  logic [DWIDTH-1:0] a_q, b_q, sum_q;
  logic              carry_q, cout_q;
  logic [IW-1:0]     idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CHUNK:0]    chunk_d;
  always_comb
    chunk_d = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, carry_q};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.a_i;
          b_q     <= bus.b_i;
          carry_q <= bus.cin_i;
          idx_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= chunk_d[CHUNK-1:0];
          carry_q <= chunk_d[CHUNK];
          idx_q   <= idx_q + IW'(1);
          if (idx_q == IW'(N - 1)) begin
            cout_q  <= chunk_d[CHUNK];
            state_q <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.sum_o      = sum_q;
  assign bus.cout_o     = cout_q;
  assign bus.op_count_o = cnt_q;
endmodule
